// File: rtl/threshold_scheduler.sv
// threshold_scheduler: sequences extremum-engine windows and commits validated min/max pairs as thresholds
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   cfg_enable/single       run enable; single = one window per sw_trigger, else continuous
//   sw_trigger              one-cycle window request (single mode)
//   cfg_log_count/shift     engine config, latched at window start onto eng_log_count/eng_shift
//   cfg_min_span            unsigned minimum accepted (max - min)
//   eng_start/done/min/max  engine handshake and window result
//   thr_lower/upper/valid   committed signed thresholds, valid after first commit
//   irq                     one-cycle pulse per commit
//   busy                    window in progress
//   win/reject/timeout_count status counters
// Optional: THRESHOLD_SCHEDULER_TIMEOUT_EN aborts a window if the engine stays silent too long.
module threshold_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  localparam int W = AXIS_TDATA_WIDTH / 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         cfg_enable,
  input  logic         cfg_single,
  input  logic         sw_trigger,
  input  logic [4:0]   cfg_log_count,
  input  logic [2:0]   cfg_shift,
  input  logic [W-1:0] cfg_min_span,
  output logic         eng_start,
  output logic [4:0]   eng_log_count,
  output logic [2:0]   eng_shift,
  input  logic         eng_done,
  input  logic [W-1:0] eng_min,
  input  logic [W-1:0] eng_max,
  output logic [W-1:0] thr_lower,
  output logic [W-1:0] thr_upper,
  output logic         thr_valid,
  output logic         irq,
  output logic         busy,
  output logic [31:0]  win_count,
  output logic [15:0]  reject_count,
  output logic [15:0]  timeout_count
);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, CHECK} state_t;
  state_t state;
  logic pending, drop, discard, accept;
  logic signed [W-1:0] res_min, res_max;
  logic [W:0] span;
  // a disable seen at any point of the window discards its outcome
  assign discard = drop || !cfg_enable;
  assign span = {res_max[W-1], res_max} - {res_min[W-1], res_min};
  assign accept = (res_max > res_min) && (span >= {1'b0, cfg_min_span});
`ifdef THRESHOLD_SCHEDULER_TIMEOUT_EN
  logic [32:0] tmo;
`else
  assign timeout_count = '0;
`endif
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      pending <= 1'b0;
      drop <= 1'b0;
      res_min <= '0;
      res_max <= '0;
      eng_start <= 1'b0;
      eng_log_count <= '0;
      eng_shift <= '0;
      thr_lower <= {1'b0, {(W-1){1'b1}}};
      thr_upper <= {1'b1, {(W-1){1'b0}}};
      thr_valid <= 1'b0;
      irq <= 1'b0;
      busy <= 1'b0;
      win_count <= '0;
      reject_count <= '0;
`ifdef THRESHOLD_SCHEDULER_TIMEOUT_EN
      tmo <= '0;
      timeout_count <= '0;
`endif
    end else begin
      eng_start <= 1'b0;
      irq <= 1'b0;
      if (sw_trigger && cfg_single && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: if (cfg_enable && (!cfg_single || sw_trigger || pending)) begin
          state <= ARM;
          busy <= 1'b1;
          eng_start <= 1'b1;
          eng_log_count <= cfg_log_count;
          eng_shift <= cfg_shift;
          pending <= 1'b0;
        end
        ARM: begin
          state <= WAIT;
          drop <= 1'b0;
`ifdef THRESHOLD_SCHEDULER_TIMEOUT_EN
          tmo <= (33'd1 << eng_log_count) + 33'd16;
`endif
        end
        WAIT: begin
          if (!cfg_enable) drop <= 1'b1;
          if (eng_done) begin
            res_min <= eng_min;
            res_max <= eng_max;
            state <= discard ? IDLE : CHECK;
            busy <= !discard;
          end
`ifdef THRESHOLD_SCHEDULER_TIMEOUT_EN
          else if (tmo == 33'd1) begin
            state <= IDLE;
            busy <= 1'b0;
            if (!discard && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else tmo <= tmo - 33'd1;
`endif
        end
        CHECK: begin
          state <= IDLE;
          busy <= 1'b0;
          if (accept) begin
            thr_lower <= res_min;
            thr_upper <= res_max;
            thr_valid <= 1'b1;
            irq <= 1'b1;
            win_count <= win_count + 32'd1;
          end else if (reject_count != 16'hFFFF) reject_count <= reject_count + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_threshold_scheduler.sv
// tb_threshold_scheduler: directed plus randomized checks of threshold_scheduler against a pair-acceptance model
module tb_threshold_scheduler;
  logic aclk = 1'b0, areset = 1'b1;
  logic cfg_enable = 1'b0, cfg_single = 1'b0, sw_trigger = 1'b0, eng_done = 1'b0;
  logic [4:0] cfg_log_count = '0;
  logic [2:0] cfg_shift = '0;
  logic [15:0] cfg_min_span = '0, eng_min = '0, eng_max = '0;
  logic eng_start, thr_valid, irq, busy;
  logic [4:0] eng_log_count;
  logic [2:0] eng_shift;
  logic [15:0] thr_lower, thr_upper, reject_count, timeout_count;
  logic [31:0] win_count;
  int errors = 0, checks = 0;
  logic [15:0] exp_lo = 16'h7FFF, exp_hi = 16'h8000;
  logic exp_valid = 1'b0;
  int exp_win = 0, exp_rej = 0;

  threshold_scheduler #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_single(cfg_single),
    .sw_trigger(sw_trigger), .cfg_log_count(cfg_log_count), .cfg_shift(cfg_shift),
    .cfg_min_span(cfg_min_span), .eng_start(eng_start), .eng_log_count(eng_log_count),
    .eng_shift(eng_shift), .eng_done(eng_done), .eng_min(eng_min), .eng_max(eng_max),
    .thr_lower(thr_lower), .thr_upper(thr_upper), .thr_valid(thr_valid), .irq(irq),
    .busy(busy), .win_count(win_count), .reject_count(reject_count), .timeout_count(timeout_count)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start;
    int n = 0;
    while (eng_start !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("start_seen", eng_start, 1'b1);
  endtask

  // Starts with eng_start visible (window in ARM); plays the engine and checks the commit outcome.
  task automatic run_window(input logic [15:0] mn, input logic [15:0] mx, input logic nxt);
    int a, b;
    logic acc;
    a = int'($signed(mn));
    b = int'($signed(mx));
    acc = (b > a) && ((b - a) >= int'(cfg_min_span));
    repeat ($urandom_range(1, 4)) tick;
    eng_min = mn;
    eng_max = mx;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    tick;
    if (acc) begin
      exp_lo = mn;
      exp_hi = mx;
      exp_valid = 1'b1;
      exp_win++;
    end else exp_rej++;
    chk("irq", irq, acc);
    chk("thr_lower", thr_lower, exp_lo);
    chk("thr_upper", thr_upper, exp_hi);
    chk("thr_valid", thr_valid, exp_valid);
    chk("win_count", win_count, 64'(exp_win));
    chk("reject_count", reject_count, 64'(exp_rej));
    tick;
    chk("irq_clear", irq, 1'b0);
    chk("next_start", eng_start, nxt);
  endtask

  initial begin
    int starts, busy_bad;
    logic [15:0] mn, mx;
    tick;
    tick;
    chk("rst_thr_lower", thr_lower, 16'h7FFF);
    chk("rst_thr_upper", thr_upper, 16'h8000);
    chk("rst_flags", {thr_valid, irq, eng_start, busy}, 4'b0);
    chk("rst_counts", {win_count, reject_count, timeout_count}, 64'd0);
    chk("rst_eng_cfg", {eng_log_count, eng_shift}, 8'd0);
    areset = 1'b0;
    cfg_enable = 1'b1;
    cfg_log_count = 5'd4;
    cfg_shift = 3'd2;
    cfg_min_span = 16'h0100;
    wait_start;
    chk("latched_log", eng_log_count, 5'd4);
    chk("latched_shift", eng_shift, 3'd2);
    chk("busy_arm", busy, 1'b1);
    run_window(16'hFE00, 16'h0300, 1'b1);
    run_window(16'h0010, 16'h0080, 1'b1);
    run_window(16'h0005, 16'h0005, 1'b1);
    cfg_log_count = 5'd6;
    tick;
    chk("log_held", eng_log_count, 5'd4);
    run_window(16'h8000, 16'h7FFF, 1'b1);
    chk("log_next", eng_log_count, 5'd6);
    for (int i = 0; i < 20; i++) begin
      cfg_min_span = 16'($urandom_range(0, 16'h2000));
      mn = 16'($urandom);
      mx = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(mn + 16'($urandom_range(0, 16'h3000)));
      run_window(mn, mx, 1'b1);
    end
    cfg_single = 1'b1;
    run_window(16'h0000, 16'h4000, 1'b0);
    starts = 0;
    repeat (10) begin
      tick;
      starts += int'(eng_start);
    end
    chk("single_idle_starts", 64'(starts), 64'd0);
    chk("single_idle_busy", busy, 1'b0);
    sw_trigger = 1'b1;
    tick;
    sw_trigger = 1'b0;
    chk("trigger_start", eng_start, 1'b1);
    tick;
    repeat (3) begin
      sw_trigger = 1'b1;
      tick;
      sw_trigger = 1'b0;
      tick;
    end
    run_window(16'hFF00, 16'h0100, 1'b1);
    run_window(16'h0000, 16'h0001, 1'b0);
    starts = 0;
    repeat (20) begin
      tick;
      starts += int'(eng_start);
    end
    chk("collapse_starts", 64'(starts), 64'd0);
    chk("collapse_busy", busy, 1'b0);
    cfg_single = 1'b0;
    cfg_log_count = 5'd3;
    wait_start;
    busy_bad = 0;
`ifdef THRESHOLD_SCHEDULER_TIMEOUT_EN
    repeat (24) begin
      tick;
      busy_bad += int'(busy !== 1'b1);
    end
    chk("tmo_busy_wait", 64'(busy_bad), 64'd0);
    tick;
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_count", timeout_count, 16'd1);
    tick;
    chk("tmo_rearm", eng_start, 1'b1);
    tick;
`else
    repeat (100) begin
      tick;
      busy_bad += int'(busy !== 1'b1);
    end
    chk("no_tmo_busy", 64'(busy_bad), 64'd0);
    chk("no_tmo_count", timeout_count, 16'd0);
`endif
    areset = 1'b1;
    cfg_enable = 1'b0;
    tick;
    areset = 1'b0;
    chk("mid_rst_thr", {thr_lower, thr_upper}, 32'h7FFF8000);
    chk("mid_rst_flags", {thr_valid, irq, eng_start, busy}, 4'b0);
    chk("mid_rst_counts", {win_count, reject_count, timeout_count}, 64'd0);
    chk("mid_rst_eng_cfg", {eng_log_count, eng_shift}, 8'd0);
    eng_min = 16'h0000;
    eng_max = 16'h7000;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    repeat (3) tick;
    chk("late_done_thr", {thr_lower, thr_upper, 15'd0, thr_valid}, 48'h7FFF80000000);
    chk("late_done_win", win_count, 32'd0);
    chk("late_done_busy", {busy, irq}, 2'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
